// File: rtl/fb_line_reader_if.sv
// Control, RAM read port and output stream of the frame-buffer line reader.
// The slave modport is the reader's view; master is the surrounding system.
interface fb_line_reader_if #(
    parameter int unsigned addr_width = 9,
    parameter int unsigned data_width = 8,
    parameter int unsigned len_width  = 10
);
    logic                  start;
    logic [addr_width-1:0] base_addr;
    logic [len_width-1:0]  length;
    logic                  busy;
    logic                  done;
    logic [addr_width-1:0] raddr;
    logic                  read_en;
    logic [data_width-1:0] rdata;
    logic [data_width-1:0] dout;
    logic                  dout_valid;
    logic                  dout_ready;
    logic                  dout_last;

    modport master (
        output start, base_addr, length, rdata, dout_ready,
        input  busy, done, raddr, read_en, dout, dout_valid, dout_last
    );

    modport slave (
        input  start, base_addr, length, rdata, dout_ready,
        output busy, done, raddr, read_en, dout, dout_valid, dout_last
    );
endinterface

// File: rtl/fb_line_reader.sv
// Scans `length` bytes of the frame-buffer RAM from base_addr (with wrap) and streams them
// out through a 2-entry FIFO that absorbs the RAM's one-cycle read latency.
module fb_line_reader #(
    parameter int unsigned addr_width = 9,
    parameter int unsigned data_width = 8,
    parameter int unsigned len_width  = 10
) (
    input logic             rclk,
    input logic             rst,
    fb_line_reader_if.slave bus
);
    localparam int unsigned Depth = 2 ** addr_width;
    localparam logic [len_width-1:0] MaxLen = len_width'(Depth);

    typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

    state_e                state_q, state_d;
    logic [addr_width-1:0] addr_q;
    logic [addr_width-1:0] raddr_q;
    logic [len_width-1:0]  reads_left_q;
    logic [len_width-1:0]  out_left_q;
    logic [data_width-1:0] mem_q [2];
    logic                  wr_ptr_q, rd_ptr_q;
    logic [1:0]            count_q, count_d;
    logic                  inflight_q;

    logic [len_width-1:0]  len_clamped;
    logic                  valid, pop, last, credit_ok, read_en;

    assign len_clamped = (bus.length > MaxLen) ? MaxLen : bus.length;
    assign valid       = (count_q != 2'd0);
    assign pop         = valid && bus.dout_ready;
    assign last        = valid && (out_left_q == len_width'(1));
    // Occupancy after this cycle's pop, counting the read whose data lands next edge.
    assign credit_ok   = (({1'b0, count_q} + {2'b00, inflight_q} - {2'b00, pop}) < 3'd2);
    assign count_d     = count_q + {1'b0, inflight_q} - {1'b0, pop};

    always_ff @(posedge rclk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (bus.start) state_d = (len_clamped == '0) ? StDone : StRun;
            StRun:   if (read_en && (reads_left_q == len_width'(1))) state_d = StDrain;
            StDrain: if (pop && last) state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        read_en        = (state_q == StRun) && credit_ok;
        bus.read_en    = read_en;
        bus.busy       = (state_q != StIdle);
        bus.done       = (state_q == StDone);
        bus.raddr      = read_en ? addr_q : raddr_q;
        bus.dout       = mem_q[rd_ptr_q];
        bus.dout_valid = valid;
        bus.dout_last  = last;
    end

    always_ff @(posedge rclk or posedge rst) begin
        if (rst) begin
            addr_q       <= '0;
            raddr_q      <= '0;
            reads_left_q <= '0;
            out_left_q   <= '0;
            inflight_q   <= 1'b0;
            wr_ptr_q     <= 1'b0;
            rd_ptr_q     <= 1'b0;
            count_q      <= 2'd0;
            for (int i = 0; i < 2; i++) mem_q[i] <= '0;
        end else begin
            if ((state_q == StIdle) && bus.start) begin
                addr_q       <= bus.base_addr;
                reads_left_q <= len_clamped;
                out_left_q   <= len_clamped;
            end else begin
                if (read_en) begin
                    addr_q       <= addr_q + addr_width'(1);
                    raddr_q      <= addr_q;
                    reads_left_q <= reads_left_q - len_width'(1);
                end
                if (pop) out_left_q <= out_left_q - len_width'(1);
            end
            inflight_q <= read_en;
            if (inflight_q) begin
                mem_q[wr_ptr_q] <= bus.rdata;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (pop) rd_ptr_q <= ~rd_ptr_q;
            count_q <= count_d;
        end
    end
endmodule

// File: tb/tb_fb_line_reader.sv
// Randomized bench for fb_line_reader: a RAM model feeds the read port and a per-cycle
// monitor compares every output against a behavioural model of the scan.
module tb_fb_line_reader;
    localparam int AW = 9;
    localparam int DW = 8;
    localparam int LW = 10;
    localparam int DEPTH = 512;

    logic rclk = 1'b0;
    logic rst  = 1'b1;
    always #5 rclk = ~rclk;

    fb_line_reader_if #(.addr_width(AW), .data_width(DW), .len_width(LW)) bus ();

    fb_line_reader #(.addr_width(AW), .data_width(DW), .len_width(LW)) dut (
        .rclk (rclk),
        .rst  (rst),
        .bus  (bus)
    );

    logic [7:0] ram [DEPTH];
    always @(posedge rclk) if (bus.read_en) bus.rdata <= ram[bus.raddr];

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Sink readiness: 0 always, 1 fixed pattern, 2 random, 3 never.
    int        rdy_mode = 0;
    int        cyc = 0;
    logic [5:0] pat = 6'b101001;
    always @(posedge rclk) begin
        cyc++;
        #1;
        case (rdy_mode)
            0: bus.dout_ready = 1'b1;
            1: bus.dout_ready = pat[cyc % 6];
            2: bus.dout_ready = 1'($urandom_range(0, 1));
            default: bus.dout_ready = 1'b0;
        endcase
    end

    // Behavioural model of a scan: addresses, byte order, timing of valid, credit, done.
    bit         m_busy = 0, m_done_exp = 0, m_prev_read = 0;
    int         m_len = 0, m_base = 0, m_reads = 0, m_hs = 0, m_arr = 0;
    bit         p_stall = 0;
    logic [7:0] p_dout;
    logic       p_last;
    logic [7:0] cap [$];
    int         rdq [$];

    always @(negedge rclk) begin
        bit pop, acc, exp_valid, exp_re;
        if (!rst) begin
            pop       = bus.dout_valid && bus.dout_ready;
            exp_valid = (m_arr - m_hs) > 0;
            exp_re    = m_busy && !m_done_exp && (m_reads < m_len)
                        && ((m_reads - m_hs - (pop ? 1 : 0)) < 2);
            check("dout_valid", bus.dout_valid, exp_valid);
            check("busy", bus.busy, m_busy);
            check("done", bus.done, m_done_exp);
            check("read_en", bus.read_en, exp_re);
            if (bus.read_en) begin
                check("raddr", bus.raddr, (m_base + m_reads) % DEPTH);
                rdq.push_back(int'(bus.raddr));
            end
            if (bus.dout_valid && (m_hs < m_len)) begin
                check("dout", bus.dout, ram[(m_base + m_hs) % DEPTH]);
                check("dout_last", bus.dout_last, (m_hs == m_len - 1));
            end
            if (p_stall) begin
                check("hold_dout", bus.dout, p_dout);
                check("hold_last", bus.dout_last, p_last);
            end
            p_stall = bus.dout_valid && !bus.dout_ready;
            p_dout  = bus.dout;
            p_last  = bus.dout_last;
            if (pop) cap.push_back(bus.dout);
            m_arr += m_prev_read ? 1 : 0;
            m_prev_read = bus.read_en;
            if (bus.read_en) m_reads++;
            if (pop) m_hs++;
            acc = bus.start && !m_busy;
            if (m_done_exp) begin
                m_done_exp = 0;
                m_busy = 0;
            end else if (pop && (m_hs == m_len)) begin
                m_done_exp = 1;
            end
            if (acc) begin
                m_base     = int'(bus.base_addr);
                m_len      = (int'(bus.length) > DEPTH) ? DEPTH : int'(bus.length);
                m_reads    = 0;
                m_hs       = 0;
                m_arr      = 0;
                m_busy     = 1;
                m_done_exp = (m_len == 0);
            end
        end
    end

    task automatic do_reset(input bit with_start);
        @(posedge rclk);
        #2;
        rst = 1'b1;
        bus.start = with_start;
        #1;
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        check("rst_read_en", bus.read_en, 0);
        check("rst_dout_valid", bus.dout_valid, 0);
        check("rst_dout_last", bus.dout_last, 0);
        check("rst_raddr", bus.raddr, 0);
        check("rst_dout", bus.dout, 0);
        m_busy = 0; m_done_exp = 0; m_prev_read = 0; p_stall = 0;
        m_len = 0; m_reads = 0; m_hs = 0; m_arr = 0;
        @(posedge rclk);
        @(posedge rclk);
        #2;
        bus.start = 1'b0;
        #1;
        rst = 1'b0;
    endtask

    task automatic run_scan(input int base, input int len, input int mode, input bit poke);
        cap.delete();
        rdq.delete();
        @(posedge rclk);
        #1;
        rdy_mode      = mode;
        bus.base_addr = AW'(base);
        bus.length    = LW'(len);
        bus.start     = 1'b1;
        @(posedge rclk);
        #1;
        bus.start     = 1'b0;
        bus.base_addr = AW'($urandom);
        bus.length    = LW'($urandom);
        if (poke && len != 0) begin
            bus.start = 1'b1;  // lands in RUN, must be ignored
            @(posedge rclk);
            #1;
            bus.start = 1'b0;
        end
        for (int k = 0; k < 5000 && m_busy; k++) @(posedge rclk);
        check("scan_timeout", m_busy, 0);
    endtask

    initial begin
        bus.start = 1'b0;
        bus.base_addr = '0;
        bus.length = '0;
        bus.dout_ready = 1'b1;
        for (int i = 0; i < DEPTH; i++) ram[i] = 8'($urandom);

        do_reset(1'b1);

        for (int i = 0; i < 4; i++) ram[16 + i] = 8'(8'hA0 + i);
        run_scan(16'h010, 4, 0, 1'b1);
        check("t2_nreads", rdq.size(), 4);
        check("t2_nbytes", cap.size(), 4);
        for (int i = 0; i < 4 && i < rdq.size() && i < cap.size(); i++) begin
            check("t2_raddr_lit", rdq[i], 16'h010 + i);
            check("t2_byte_lit", cap[i], 8'hA0 + i);
        end

        ram[9'h1FE] = 8'h11; ram[9'h1FF] = 8'h22; ram[9'h000] = 8'h33; ram[9'h001] = 8'h44;
        run_scan(16'h1FE, 4, 0, 1'b0);
        if (rdq.size() == 4 && cap.size() == 4) begin
            check("t3_raddr0", rdq[0], 9'h1FE);
            check("t3_raddr1", rdq[1], 9'h1FF);
            check("t3_raddr2", rdq[2], 9'h000);
            check("t3_raddr3", rdq[3], 9'h001);
            check("t3_byte0", cap[0], 8'h11);
            check("t3_byte3", cap[3], 8'h44);
        end else begin
            check("t3_count", rdq.size() * 16 + cap.size(), 4 * 16 + 4);
        end

        run_scan(16'h040, 8, 1, 1'b1);
        check("t4_nbytes", cap.size(), 8);
        for (int i = 0; i < 8 && i < cap.size(); i++) check("t4_byte", cap[i], ram[16'h040 + i]);

        run_scan(16'h123, 0, 0, 1'b0);
        check("t5_zero_reads", rdq.size(), 0);
        check("t5_zero_bytes", cap.size(), 0);
        run_scan(16'h0AB, 600, 2, 1'b1);
        check("t5_clamp_bytes", cap.size(), 512);
        check("t5_clamp_reads", rdq.size(), 512);

        // Two bytes parked in the FIFO with the sink stalled, then reset.
        cap.delete();
        @(posedge rclk);
        #1;
        rdy_mode = 3;
        bus.base_addr = 9'h077;
        bus.length = 10'd2;
        bus.start = 1'b1;
        @(posedge rclk);
        #1;
        bus.start = 1'b0;
        repeat (6) @(posedge rclk);
        #3;
        check("t6_parked_valid", bus.dout_valid, 1);
        check("t6_parked_busy", bus.busy, 1);
        check("t6_no_bytes", cap.size(), 0);
        do_reset(1'b0);
        repeat (3) @(posedge rclk);
        run_scan(16'h055, 5, 0, 1'b0);
        check("t6_clean_bytes", cap.size(), 5);

        for (int s = 0; s < 15; s++) begin
            int len;
            len = ($urandom_range(0, 4) == 0) ? $urandom_range(513, 1023) : $urandom_range(1, 40);
            run_scan($urandom_range(0, DEPTH - 1), len, 2, 1'($urandom_range(0, 1)));
            check("rand_nbytes", cap.size(), (len > DEPTH) ? DEPTH : len);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
